featuremap_conv_sequencer: RTL
==============================

Name: featuremap_conv_sequencer

Overview:
Controller for one 8-channel conv2d feature-map layer. It pops the eight channel FIFOs in lockstep and inserts the one-pixel zero border the 3x3 datapath expects, so the datapath sees a (HEIGHT+2)x(WIDTH+2) raster. It drops the wrap-around results the datapath produces at row ends and signals frame completion. It sits between the layer input FIFOs and the featuremap filter instances.

Parameters:
DATA_WIDTH, 32, word width (IEEE-754 single)
WIDTH, 112, unpadded feature-map width
HEIGHT, 112, unpadded feature-map height
NUM_CH, 8, input channels; all popped together

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; begins a frame when idle
fifo_data  input  NUM_CH*DATA_WIDTH  show-ahead FIFO heads, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
fifo_empty  input  NUM_CH  per-channel empty flags
fifo_rdreq  output  1  shared pop to all channel FIFOs
pad_data  output  NUM_CH*DATA_WIDTH  padded stream to datapath channel inputs
pad_valid  output  1  pad_data valid (drives datapath valid_in)
conv_data  input  DATA_WIDTH  result from the add_bias stage
conv_valid  input  1  result valid
out_data  output  DATA_WIDTH  filtered result
out_valid  output  1  out_data valid
busy  output  1  high from start acceptance until frame_done
frame_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, any time, including mid-frame): state IDLE; all counters 0; fifo_rdreq, pad_valid, out_valid, busy, frame_done = 0; pad_data and out_data = 0. No partial-frame recovery.
- States:
  - IDLE: start -> RUN, busy=1. Start outside IDLE is ignored.
  - RUN: input counters prow (0..HEIGHT+1) and pcol (0..WIDTH+1) walk the padded raster.
    - Border position (prow=0, prow=HEIGHT+1, pcol=0 or pcol=WIDTH+1): emit all-zero pad_data; fifo_rdreq=0; advance every cycle.
    - Interior position: fifo_rdreq = &(~fifo_empty) (combinational, same cycle). The position advances only on a cycle where fifo_rdreq=1. When any FIFO is empty, wait: no pop, no emit.
    - Emit of last position (HEIGHT+1, WIDTH+1) -> DRAIN.
  - DRAIN: wait until the output counter completes the frame -> DONE.
  - DONE: frame_done=1 for one cycle, busy=0 -> IDLE.
- pad path: registered, 1-cycle latency. A cycle that emits (border, or interior with pop) gives pad_valid=1 next cycle, with pad_data = zeros or the fifo_data captured at the pop.
- Output filter:
  - Counters ocol (0..WIDTH+1) and orow (0..HEIGHT-1) advance on each conv_valid while in RUN or DRAIN.
  - ocol<WIDTH: out_data<=conv_data, out_valid=1 next cycle (1-cycle latency).
  - ocol=WIDTH or WIDTH+1: result dropped.
  - At ocol=WIDTH+1, orow=HEIGHT-1: frame complete. Counters clear.
  - conv_valid in IDLE or DONE is ignored.
- Totals per frame: (HEIGHT+2)*(WIDTH+2) pad_valid beats; HEIGHT*WIDTH pops; HEIGHT*(WIDTH+2) conv_valid accepted; HEIGHT*WIDTH out_valid.
- A start in the same cycle as frame_done is ignored; start must arrive at least one cycle after frame_done.

Test Plan:
- WIDTH=4, HEIGHT=3, all FIFOs always non-empty, start pulse -> 30 pad_valid beats. First 7 beats and every beat at pcol 0/5 are zero. Exactly 12 pops. Pad output is contiguous (no gaps).
- Same frame; conv model returns 18 results with values 0..17 -> out_valid 12 times, values 0-3, 6-9, 12-15. frame_done pulses once one cycle after the 18th conv_valid is accepted; busy falls with it.
- Channel 5 empty for 10 cycles at interior position (1,1) -> fifo_rdreq=0 and pad_valid=0 during the stall. Stream resumes with the correct channel-5 word. Pop count is still 12.
- Start pulsed again mid-RUN -> ignored; counters and totals unchanged.
- Reset asserted mid-RUN at position (2,3) -> all outputs 0 immediately (asynchronous). A new start replays the full 30-beat frame from (0,0).
- Spurious conv_valid in IDLE -> no out_valid; ocol stays 0.

Source files
------------

// File: rtl/featuremap_conv_sequencer.sv
// Sequencer for one conv2d feature-map layer: pops the channel FIFOs in lockstep, wraps the
// image in a one-pixel zero border, and trims the row-end wrap-around results from the datapath.
module featuremap_conv_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 112,
  parameter int HEIGHT     = 112,
  parameter int NUM_CH     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_data,
  input  logic [NUM_CH-1:0]            fifo_empty,
  output logic                         fifo_rdreq,
  output logic [NUM_CH*DATA_WIDTH-1:0] pad_data,
  output logic                         pad_valid,
  input  logic [DATA_WIDTH-1:0]        conv_data,
  input  logic                         conv_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int PRW = $clog2(HEIGHT + 2);
  localparam int PCW = $clog2(WIDTH + 2);
  localparam int ORW = $clog2(HEIGHT + 1);
  localparam logic [PRW-1:0] PROW_LAST = PRW'(HEIGHT + 1);
  localparam logic [PCW-1:0] PCOL_LAST = PCW'(WIDTH + 1);
  localparam logic [PCW-1:0] OCOL_DROP = PCW'(WIDTH);
  localparam logic [ORW-1:0] OROW_LAST = ORW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_next;
  logic [PRW-1:0]   prow;
  logic [PCW-1:0]   pcol;
  logic [PCW-1:0]   ocol;
  logic [ORW-1:0]   orow;
  logic             out_complete;
  logic             on_border, all_ready, emit, last_pos;
  logic             accept, keep_result, frame_complete;

  always_comb begin
    on_border      = (prow == '0) || (prow == PROW_LAST) || (pcol == '0) || (pcol == PCOL_LAST);
    all_ready      = &(~fifo_empty);
    emit           = (state == RUN) && (on_border || all_ready);
    last_pos       = (prow == PROW_LAST) && (pcol == PCOL_LAST);
    accept         = conv_valid && ((state == RUN) || (state == DRAIN));
    keep_result    = accept && (ocol < OCOL_DROP);
    frame_complete = accept && (ocol == PCOL_LAST) && (orow == OROW_LAST);
  end

  assign fifo_rdreq = (state == RUN) && !on_border && all_ready;
  assign busy       = (state == RUN) || (state == DRAIN);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (emit && last_pos) state_next = DRAIN;
      DRAIN:   if (out_complete || frame_complete) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Raster position wraps back to (0,0) on the final emit, so the next frame starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prow <= '0;
      pcol <= '0;
    end else if (emit) begin
      if (pcol == PCOL_LAST) begin
        pcol <= '0;
        prow <= last_pos ? '0 : prow + 1'b1;
      end else begin
        pcol <= pcol + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_valid <= 1'b0;
      pad_data  <= '0;
    end else begin
      pad_valid <= emit;
      pad_data  <= (emit && !on_border) ? fifo_data : '0;
    end
  end

  // The output grid is WIDTH+2 results wide; the last two per row are wrap-around garbage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ocol <= '0;
      orow <= '0;
    end else if (accept) begin
      if (ocol == PCOL_LAST) begin
        ocol <= '0;
        orow <= (orow == OROW_LAST) ? '0 : orow + 1'b1;
      end else begin
        ocol <= ocol + 1'b1;
      end
    end
  end

  // Remembers a frame that finished before the input side reached DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 out_complete <= 1'b0;
    else if (state == DONE)  out_complete <= 1'b0;
    else if (frame_complete) out_complete <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= keep_result;
      if (keep_result) out_data <= conv_data;
    end
  end

endmodule
